// File: rtl/hazard_pkg.sv
// Shared types for the hazard/stall controller: FSM states, the packed control bundle
// and the canned control patterns the top decodes into.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         TMR_W    = 16;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
    logic br_flush;       // marks a taken-branch squash, feeds the flush counter
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_WAIT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2,
                                        input logic       uses_rs2);
    return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Latency: count visible the cycle after the event.
// Backpressure: none, sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush control for load-use, taken-branch and data-memory wait hazards.
// Latency: enables/flushes are combinational from state and inputs; counters and err_o one cycle.
// Backpressure: a pending dmem access freezes every stage until ready or timeout.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int INIT_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       IF_ID_RS1_i,
  input  logic [4:0]       IF_ID_RS2_i,
  input  logic             ID_uses_rs2_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic             EX_branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             clear_cnt_i,
  output logic             PC_en_o,
  output logic             IF_ID_en_o,
  output logic             ID_EX_en_o,
  output logic             EX_MEM_en_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic             MEM_WB_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
  ctrl_t            ctrl;
  logic             load_use;
  logic             stall_inc;

  assign load_use = load_use_hit(ID_EX_MemRead_i, ID_EX_RD_i, IF_ID_RS1_i, IF_ID_RS2_i,
                                 ID_uses_rs2_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  // tmr_q counts INIT cycles, then reused as the count of wait cycles already spent.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    ctrl    = CTRL_RUN;
    case (state_q)
      INIT: begin
        ctrl = CTRL_FREEZE;
        if (tmr_q == TMR_W'(INIT_CYCLES - 1)) begin
          state_d = RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          ctrl    = CTRL_WAIT;
          state_d = MEM_WAIT;
          tmr_d   = TMR_W'(1);
        end else if (EX_branch_taken_i) begin
          ctrl = CTRL_BRANCH;
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          ctrl    = CTRL_RUN;
          state_d = RUN;
        end else begin
          ctrl = CTRL_WAIT;
          // This cycle is wait cycle tmr_q+1; give up once it hits the limit.
          if (tmr_q >= TMR_W'(MEM_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = RUN;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      default: begin
        ctrl    = CTRL_RUN;
        state_d = RUN;
      end
    endcase
  end

  assign stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT)) && !ctrl.pc_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_inc),
    .clr_i  (clear_cnt_i),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ctrl.br_flush),
    .clr_i  (clear_cnt_i),
    .cnt_o  (flush_cnt_o)
  );

  assign PC_en_o         = ctrl.pc_en;
  assign IF_ID_en_o      = ctrl.if_id_en;
  assign ID_EX_en_o      = ctrl.id_ex_en;
  assign EX_MEM_en_o     = ctrl.ex_mem_en;
  assign IF_ID_flush_o   = ctrl.if_id_flush;
  assign ID_EX_flush_o   = ctrl.id_ex_flush;
  assign MEM_WB_bubble_o = ctrl.mem_wb_bubble;
  assign err_o           = err_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: reset/INIT, load-use, branch priority,
// memory wait, timeout, counter saturation/clear and reset abort of a wait.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  // {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble}
  localparam logic [6:0] O_FREEZE = 7'b0000_111;
  localparam logic [6:0] O_WAIT   = 7'b0000_001;
  localparam logic [6:0] O_BRANCH = 7'b1111_110;
  localparam logic [6:0] O_LU     = 7'b0011_010;
  localparam logic [6:0] O_RUN    = 7'b1111_000;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [4:0]       IF_ID_RS1_i, IF_ID_RS2_i, ID_EX_RD_i;
  logic             ID_uses_rs2_i, ID_EX_MemRead_i, EX_branch_taken_i;
  logic             dmem_req_i, dmem_ready_i, clear_cnt_i;
  logic             PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o;
  logic             IF_ID_flush_o, ID_EX_flush_o, MEM_WB_bubble_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(8), .INIT_CYCLES(2)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .IF_ID_RS1_i       (IF_ID_RS1_i),
    .IF_ID_RS2_i       (IF_ID_RS2_i),
    .ID_uses_rs2_i     (ID_uses_rs2_i),
    .ID_EX_MemRead_i   (ID_EX_MemRead_i),
    .ID_EX_RD_i        (ID_EX_RD_i),
    .EX_branch_taken_i (EX_branch_taken_i),
    .dmem_req_i        (dmem_req_i),
    .dmem_ready_i      (dmem_ready_i),
    .clear_cnt_i       (clear_cnt_i),
    .PC_en_o           (PC_en_o),
    .IF_ID_en_o        (IF_ID_en_o),
    .ID_EX_en_o        (ID_EX_en_o),
    .EX_MEM_en_o       (EX_MEM_en_o),
    .IF_ID_flush_o     (IF_ID_flush_o),
    .ID_EX_flush_o     (ID_EX_flush_o),
    .MEM_WB_bubble_o   (MEM_WB_bubble_o),
    .err_o             (err_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, 32'({PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o,
                  IF_ID_flush_o, ID_EX_flush_o, MEM_WB_bubble_o}), 32'(exp));
  endtask

  task automatic idle();
    IF_ID_RS1_i = 5'd0; IF_ID_RS2_i = 5'd0; ID_EX_RD_i = 5'd0;
    ID_uses_rs2_i = 1'b0; ID_EX_MemRead_i = 1'b0; EX_branch_taken_i = 1'b0;
    dmem_req_i = 1'b0; dmem_ready_i = 1'b0; clear_cnt_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;

    // Reset held 3 cycles, then two INIT cycles before RUN.
    repeat (3) tick();
    chk_outs("rst_outs", O_FREEZE);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    chk("rst_flush", 32'(flush_cnt_o), 32'd0);
    chk("rst_err",   32'(err_o),       32'd0);
    rst_ni = 1'b1;
    chk_outs("init_c1", O_FREEZE);
    tick();
    chk_outs("init_c2", O_FREEZE);
    tick();
    chk_outs("run_after_init", O_RUN);
    chk("init_not_counted", 32'(stall_cnt_o), 32'd0);

    // Load-use on rs1.
    ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd5; IF_ID_RS1_i = 5'd5;
    chk_outs("lu_rs1", O_LU);
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
    ID_EX_MemRead_i = 1'b0;
    chk_outs("lu_cleared", O_RUN);
    // Destination x0 is never a hazard.
    ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd0; IF_ID_RS1_i = 5'd0;
    chk_outs("lu_x0", O_RUN);
    tick();
    // rs2 match ignored unless the instruction reads rs2.
    ID_EX_RD_i = 5'd5; IF_ID_RS1_i = 5'd3; IF_ID_RS2_i = 5'd5; ID_uses_rs2_i = 1'b0;
    chk_outs("lu_rs2_unused", O_RUN);
    ID_uses_rs2_i = 1'b1;
    chk_outs("lu_rs2_used", O_LU);
    tick();
    chk("lu_stall_cnt2", 32'(stall_cnt_o), 32'd2);
    idle();
    clear_cnt_i = 1'b1;
    tick();
    clear_cnt_i = 1'b0;
    chk("clr_stall", 32'(stall_cnt_o), 32'd0);

    // Branch overrides load-use.
    ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd5; IF_ID_RS1_i = 5'd5; EX_branch_taken_i = 1'b1;
    chk_outs("br_over_lu", O_BRANCH);
    tick();
    idle();
    chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Memory wait: ready low 4 cycles, branch during wait ignored.
    dmem_req_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      EX_branch_taken_i = (i == 3);
      chk_outs($sformatf("mw_c%0d", i), O_WAIT);
      tick();
    end
    EX_branch_taken_i = 1'b0;
    dmem_ready_i = 1'b1;
    chk_outs("mw_ready", O_RUN);
    tick();
    idle();
    chk("mw_stall_cnt", 32'(stall_cnt_o), 32'd4);
    chk("mw_flush_cnt", 32'(flush_cnt_o), 32'd1);
    chk("mw_err", 32'(err_o), 32'd0);
    chk_outs("mw_back_run", O_RUN);

    // Timeout after 8 wait cycles.
    clear_cnt_i = 1'b1;
    tick();
    clear_cnt_i = 1'b0;
    dmem_req_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk_outs($sformatf("to_outs_c%0d", i), O_WAIT);
      tick();
      if (i == 8) dmem_req_i = 1'b0;
      chk($sformatf("to_err_c%0d", i), 32'(err_o), (i == 8) ? 32'd1 : 32'd0);
    end
    chk_outs("to_state_run", O_RUN);
    chk("to_stall_cnt", 32'(stall_cnt_o), 32'd8);
    repeat (3) tick();
    chk("to_err_sticky", 32'(err_o), 32'd1);

    // Flush counter saturates at 15; clear beats a same-cycle branch.
    clear_cnt_i = 1'b1;
    tick();
    clear_cnt_i = 1'b0;
    EX_branch_taken_i = 1'b1;
    repeat (20) tick();
    chk("sat_flush", 32'(flush_cnt_o), 32'd15);
    clear_cnt_i = 1'b1;
    tick();
    idle();
    chk("clr_wins", 32'(flush_cnt_o), 32'd0);
    chk("err_still_set", 32'(err_o), 32'd1);

    // Reset clears err; reset during a wait aborts it.
    rst_ni = 1'b0;
    tick();
    chk("rst2_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    repeat (2) tick();
    dmem_req_i = 1'b1;
    chk_outs("abort_wait_entry", O_WAIT);
    tick();
    chk_outs("abort_in_wait", O_WAIT);
    rst_ni = 1'b0;
    tick();
    chk_outs("abort_rst", O_FREEZE);
    dmem_req_i = 1'b0;
    rst_ni = 1'b1;
    repeat (2) tick();
    chk_outs("abort_run", O_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
